// File: rtl/bu_mac_pipe.sv
// ============================================================================
//  Module      : bu_mac_pipe
//  Description : Pipelined single-precision multiply-add butterfly, result =
//                f(a*b, c), with aligned addend/mode/tag delay lines, valid
//                tracking and an in-flight counter. Optional sticky flags are
//                enabled by defining BU_STICKY_FLAGS_EN.
//                fpmult/fpadd are synthesizable stand-ins for the vendor cores
//                (flush-to-zero, round-to-nearest-even).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpmult #(
    parameter int LATENCY = 5
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);
    logic               w_sign, w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
    logic [47:0]        w_prod;
    logic [24:0]        w_mant;
    logic               w_g, w_st, w_ovf, w_udf;
    logic [1:0]         w_adj;
    logic signed [10:0] w_exp;
    logic [31:0]        w_res;
    logic [33:0]        r_pipe [LATENCY];

    always_comb begin
        w_sign   = dataa[31] ^ datab[31];
        w_inf_a  = (dataa[30:23] == 8'hFF) && (dataa[22:0] == '0);
        w_inf_b  = (datab[30:23] == 8'hFF) && (datab[22:0] == '0);
        w_nan_a  = (dataa[30:23] == 8'hFF) && (dataa[22:0] != '0);
        w_nan_b  = (datab[30:23] == 8'hFF) && (datab[22:0] != '0);
        w_zero_a = (dataa[30:23] == 8'h00);
        w_zero_b = (datab[30:23] == 8'h00);
        w_prod   = {1'b1, dataa[22:0]} * {1'b1, datab[22:0]};
        if (w_prod[47]) begin
            w_mant = {1'b0, w_prod[47:24]};
            w_g    = w_prod[23];
            w_st   = |w_prod[22:0];
            w_adj  = 2'd1;
        end else begin
            w_mant = {1'b0, w_prod[46:23]};
            w_g    = w_prod[22];
            w_st   = |w_prod[21:0];
            w_adj  = 2'd0;
        end
        w_mant = w_mant + {24'b0, w_g & (w_st | w_mant[0])};
        if (w_mant[24]) begin
            w_mant = {1'b0, w_mant[24:1]};
            w_adj  = w_adj + 2'd1;
        end
        w_exp = $signed({3'b000, dataa[30:23]}) + $signed({3'b000, datab[30:23]})
              + $signed({9'b0, w_adj}) - 11'sd127;
        w_res = '0;
        w_ovf = 1'b0;
        w_udf = 1'b0;
        if (w_nan_a || w_nan_b || (w_inf_a && w_zero_b) || (w_zero_a && w_inf_b)) begin
            w_res = 32'h7FC0_0000;
        end else if (w_inf_a || w_inf_b) begin
            w_res = {w_sign, 8'hFF, 23'b0};
        end else if (w_zero_a || w_zero_b) begin
            w_res = {w_sign, 31'b0};
        end else if (w_exp >= 11'sd255) begin
            w_res = {w_sign, 8'hFF, 23'b0};
            w_ovf = 1'b1;
        end else if (w_exp <= 11'sd0 || !w_mant[23]) begin
            w_res = {w_sign, 31'b0};
            w_udf = 1'b1;
        end else begin
            w_res = {w_sign, w_exp[7:0], w_mant[22:0]};
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
        end else if (clk_en) begin
            r_pipe[0] <= {w_ovf, w_udf, w_res};
            for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign result    = r_pipe[LATENCY-1][31:0];
    assign underflow = r_pipe[LATENCY-1][32];
    assign overflow  = r_pipe[LATENCY-1][33];
endmodule

module fpadd #(
    parameter int LATENCY = 6
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        zero
);
    logic               w_inf_a, w_inf_b, w_nan_a, w_nan_b, w_zero_a, w_zero_b;
    logic [30:0]        w_key_a, w_key_b;
    logic               w_big_s, w_sml_s, w_lost, w_found;
    logic [7:0]         w_big_e, w_d;
    logic [23:0]        w_big_m, w_sml_m;
    logic [27:0]        w_big_x, w_sml_x0, w_sml_x, w_mask, w_sum;
    logic [26:0]        w_n;
    logic [4:0]         w_lz;
    logic [24:0]        w_rnd;
    logic signed [10:0] w_e;
    logic [31:0]        w_res;
    logic               w_ovf, w_udf, w_zero;
    logic [34:0]        r_pipe [LATENCY];

    always_comb begin
        w_inf_a  = (dataa[30:23] == 8'hFF) && (dataa[22:0] == '0);
        w_inf_b  = (datab[30:23] == 8'hFF) && (datab[22:0] == '0);
        w_nan_a  = (dataa[30:23] == 8'hFF) && (dataa[22:0] != '0);
        w_nan_b  = (datab[30:23] == 8'hFF) && (datab[22:0] != '0);
        w_zero_a = (dataa[30:23] == 8'h00);
        w_zero_b = (datab[30:23] == 8'h00);
        // Denormals are flushed: a zero exponent contributes no magnitude.
        w_key_a  = {dataa[30:23], w_zero_a ? 23'b0 : dataa[22:0]};
        w_key_b  = {datab[30:23], w_zero_b ? 23'b0 : datab[22:0]};
        if (w_key_a >= w_key_b) begin
            w_big_s = dataa[31]; w_big_e = dataa[30:23];
            w_big_m = w_zero_a ? 24'b0 : {1'b1, dataa[22:0]};
            w_sml_s = datab[31]; w_d = dataa[30:23] - datab[30:23];
            w_sml_m = w_zero_b ? 24'b0 : {1'b1, datab[22:0]};
        end else begin
            w_big_s = datab[31]; w_big_e = datab[30:23];
            w_big_m = w_zero_b ? 24'b0 : {1'b1, datab[22:0]};
            w_sml_s = dataa[31]; w_d = datab[30:23] - dataa[30:23];
            w_sml_m = w_zero_a ? 24'b0 : {1'b1, dataa[22:0]};
        end
        w_big_x  = {1'b0, w_big_m, 3'b000};
        w_sml_x0 = {1'b0, w_sml_m, 3'b000};
        w_mask   = (28'd1 << w_d) - 28'd1;
        w_lost   = |(w_sml_x0 & w_mask);
        if (w_d >= 8'd27) w_sml_x = {27'b0, |w_sml_m};
        else              w_sml_x = (w_sml_x0 >> w_d) | {27'b0, w_lost};
        w_sum = (w_big_s == w_sml_s) ? (w_big_x + w_sml_x) : (w_big_x - w_sml_x);

        w_lz    = '0;
        w_found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!w_found && w_sum[i]) begin
                w_lz    = 5'(26 - i);
                w_found = 1'b1;
            end
        end
        w_e = $signed({3'b000, w_big_e});
        if (w_sum[27]) begin
            w_n = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_e = w_e + 11'sd1;
        end else begin
            w_n = w_sum[26:0] << w_lz;
            w_e = w_e - $signed({6'b0, w_lz});
        end
        w_rnd = {1'b0, w_n[26:3]} + {24'b0, w_n[2] & (w_n[1] | w_n[0] | w_n[3])};
        if (w_rnd[24]) begin
            w_rnd = {1'b0, w_rnd[24:1]};
            w_e   = w_e + 11'sd1;
        end

        w_res  = '0;
        w_ovf  = 1'b0;
        w_udf  = 1'b0;
        w_zero = 1'b0;
        if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (dataa[31] != datab[31]))) begin
            w_res = 32'h7FC0_0000;
        end else if (w_inf_a) begin
            w_res = {dataa[31], 8'hFF, 23'b0};
        end else if (w_inf_b) begin
            w_res = {datab[31], 8'hFF, 23'b0};
        end else if (w_sum == '0) begin
            w_zero = 1'b1;
        end else if (w_e >= 11'sd255) begin
            w_res = {w_big_s, 8'hFF, 23'b0};
            w_ovf = 1'b1;
        end else if (w_e <= 11'sd0 || !w_rnd[23]) begin
            w_res  = {w_big_s, 31'b0};
            w_udf  = 1'b1;
            w_zero = 1'b1;
        end else begin
            w_res = {w_big_s, w_e[7:0], w_rnd[22:0]};
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
        end else if (clk_en) begin
            r_pipe[0] <= {w_zero, w_ovf, w_udf, w_res};
            for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign result    = r_pipe[LATENCY-1][31:0];
    assign underflow = r_pipe[LATENCY-1][32];
    assign overflow  = r_pipe[LATENCY-1][33];
    assign zero      = r_pipe[LATENCY-1][34];
endmodule

module bu_mac_pipe #(
    parameter int MUL_LAT = 5,
    parameter int ADD_LAT = 6,
    parameter int TAG_W   = 4
) (
    input  logic             clock,
    input  logic             aclr_n,
    input  logic             clk_en,
    input  logic             in_valid,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [31:0]      dataa_mul,
    input  logic [31:0]      datab_mul,
    input  logic [31:0]      data_c,
    output logic             out_valid,
    output logic [31:0]      result,
    output logic [TAG_W-1:0] out_tag,
    output logic             zero,
    output logic             overflow,
    output logic             underflow,
`ifdef BU_STICKY_FLAGS_EN
    input  logic             clr_flags,
    output logic             sticky_ovf,
    output logic             sticky_udf,
`endif
    output logic             busy
);
    localparam int         L     = MUL_LAT + ADD_LAT;
    localparam int         CNT_W = $clog2(L + 1);
    localparam logic [1:0] c_mode_sub  = 2'b01;
    localparam logic [1:0] c_mode_rsub = 2'b10;
    localparam logic [1:0] c_mode_mul  = 2'b11;

    logic [31:0]        w_mul_res, w_add_a, w_add_b, w_c_d;
    logic               w_mul_ovf, w_mul_udf, w_add_ovf, w_add_udf;
    logic [1:0]         w_mode_d;
    logic [TAG_W-1:0]   w_tag_d;
    logic               w_accept, w_retire;
    // Stage words: {tag, mode, c} ahead of the adder, {tag, mul_ovf, mul_udf} beside it.
    logic [TAG_W+33:0]  r_s1 [MUL_LAT];
    logic [TAG_W+1:0]   r_s2 [ADD_LAT];
    logic [L-1:0]       r_valid;
    logic [CNT_W-1:0]   r_cnt;

    fpmult #(.LATENCY(MUL_LAT)) u_fpmult (
        .clock     (clock),
        .aclr      (~aclr_n),
        .clk_en    (clk_en),
        .dataa     (dataa_mul),
        .datab     (datab_mul),
        .result    (w_mul_res),
        .overflow  (w_mul_ovf),
        .underflow (w_mul_udf)
    );

    assign w_c_d    = r_s1[MUL_LAT-1][31:0];
    assign w_mode_d = r_s1[MUL_LAT-1][33:32];
    assign w_tag_d  = r_s1[MUL_LAT-1][TAG_W+33:34];

    always_comb begin
        w_add_a = w_mul_res;
        w_add_b = w_c_d;
        case (w_mode_d)
            c_mode_sub:  w_add_b = {~w_c_d[31], w_c_d[30:0]};
            c_mode_rsub: w_add_a = {~w_mul_res[31], w_mul_res[30:0]};
            c_mode_mul:  w_add_b = 32'h0000_0000;
            default:     w_add_b = w_c_d;
        endcase
    end

    fpadd #(.LATENCY(ADD_LAT)) u_fpadd (
        .clock     (clock),
        .aclr      (~aclr_n),
        .clk_en    (clk_en),
        .dataa     (w_add_a),
        .datab     (w_add_b),
        .result    (result),
        .overflow  (w_add_ovf),
        .underflow (w_add_udf),
        .zero      (zero)
    );

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            for (int i = 0; i < MUL_LAT; i++) r_s1[i] <= '0;
            for (int i = 0; i < ADD_LAT; i++) r_s2[i] <= '0;
            r_valid <= '0;
        end else if (clk_en) begin
            r_s1[0] <= {in_tag, in_mode, data_c};
            for (int i = 1; i < MUL_LAT; i++) r_s1[i] <= r_s1[i-1];
            r_s2[0] <= {w_tag_d, w_mul_ovf, w_mul_udf};
            for (int i = 1; i < ADD_LAT; i++) r_s2[i] <= r_s2[i-1];
            r_valid <= {r_valid[L-2:0], in_valid};
        end
    end

    assign out_valid = r_valid[L-1];
    assign out_tag   = r_s2[ADD_LAT-1][TAG_W+1:2];
    assign overflow  = w_add_ovf | r_s2[ADD_LAT-1][1];
    assign underflow = w_add_udf | r_s2[ADD_LAT-1][0];

    assign w_accept = clk_en & in_valid;
    assign w_retire = clk_en & out_valid;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_cnt <= '0;
        end else if (w_accept && !w_retire && (r_cnt != CNT_W'(L))) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (!w_accept && w_retire && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign busy = (r_cnt != '0);

`ifdef BU_STICKY_FLAGS_EN
    // A flag raised in the same cycle as a clear must survive.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            sticky_ovf <= 1'b0;
            sticky_udf <= 1'b0;
        end else begin
            if (w_retire && overflow)  sticky_ovf <= 1'b1;
            else if (clr_flags)        sticky_ovf <= 1'b0;
            if (w_retire && underflow) sticky_udf <= 1'b1;
            else if (clr_flags)        sticky_udf <= 1'b0;
        end
    end
`endif
endmodule

`default_nettype wire

// File: tb/tb_bu_mac_pipe.sv
// ============================================================================
//  Module      : tb_bu_mac_pipe
//  Description : Scoreboard bench for bu_mac_pipe; expected results come from
//                a real-arithmetic model of f(a*b, c).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bu_mac_pipe;
    localparam int  TAG_W  = 4;
    localparam real TWO128 = 340282366920938463463374607431768211456.0;
    localparam real TWOM126 = 1.1754943508222875e-38;

    logic             clock = 1'b0;
    logic             aclr_n, clk_en, in_valid;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      dataa_mul, datab_mul, data_c;
    logic             out_valid, zero, overflow, underflow, busy;
    logic [31:0]      result;
    logic [TAG_W-1:0] out_tag;
`ifdef BU_STICKY_FLAGS_EN
    logic             clr_flags, sticky_ovf, sticky_udf;
`endif

    bu_mac_pipe #(.MUL_LAT(5), .ADD_LAT(6), .TAG_W(TAG_W)) dut (
        .clock(clock), .aclr_n(aclr_n), .clk_en(clk_en), .in_valid(in_valid),
        .in_mode(in_mode), .in_tag(in_tag), .dataa_mul(dataa_mul),
        .datab_mul(datab_mul), .data_c(data_c), .out_valid(out_valid),
        .result(result), .out_tag(out_tag), .zero(zero), .overflow(overflow),
        .underflow(underflow),
`ifdef BU_STICKY_FLAGS_EN
        .clr_flags(clr_flags), .sticky_ovf(sticky_ovf), .sticky_udf(sticky_udf),
`endif
        .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        logic             zero, ovf, udf;
        int               cyc;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'h00) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (e >= 255) return {d[63], 8'hFF, 23'h0};
        if (e <= 0)   return {d[63], 31'h0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic real fabs(input real r);
        return (r < 0.0) ? -r : r;
    endfunction

    function automatic exp_t model(input logic [31:0] a, b, c, input logic [1:0] mode,
                                   input logic [TAG_W-1:0] tag, input int due);
        exp_t e;
        real  p, r;
        p     = f2r(a) * f2r(b);
        e.tag = tag;
        e.cyc = due;
        e.udf = (p != 0.0) && (fabs(p) < TWOM126);
        if (fabs(p) >= TWO128) begin
            e.res  = {(p < 0.0) ^ (mode == 2'b10), 8'hFF, 23'h0};
            e.ovf  = 1'b1;
            e.zero = 1'b0;
        end else begin
            case (mode)
                2'b00:   r = p + f2r(c);
                2'b01:   r = p - f2r(c);
                2'b10:   r = f2r(c) - p;
                default: r = p;
            endcase
            e.res  = r2f(r);
            e.ovf  = fabs(r) >= TWO128;
            e.zero = (r == 0.0);
            e.udf  = e.udf || ((r != 0.0) && (fabs(r) < TWOM126));
        end
        return e;
    endfunction

    always @(negedge clock) begin
        if (aclr_n && clk_en && out_valid) begin
            if (q.size() == 0) begin
                chk_eq("spurious_valid", {63'b0, out_valid}, 64'd0);
            end else begin
                m_e = q.pop_front();
                chk_eq("result",    {32'b0, result},        {32'b0, m_e.res});
                chk_eq("tag",       {60'b0, out_tag},       {60'b0, m_e.tag});
                chk_eq("zero",      {63'b0, zero},          {63'b0, m_e.zero});
                chk_eq("overflow",  {63'b0, overflow},      {63'b0, m_e.ovf});
                chk_eq("underflow", {63'b0, underflow},     {63'b0, m_e.udf});
                chk_eq("latency",   64'(cyc),               64'(m_e.cyc));
            end
        end
    end

    task automatic issue(input logic [31:0] a, b, c, input logic [1:0] mode,
                         input logic [TAG_W-1:0] tag, input int lat);
        in_valid  = 1'b1;
        dataa_mul = a;
        datab_mul = b;
        data_c    = c;
        in_mode   = mode;
        in_tag    = tag;
        q.push_back(model(a, b, c, mode, tag, cyc + lat));
        @(posedge clock); #1;
        in_valid  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        chk_eq("drain", 64'(q.size()), 64'd0);
        chk_eq("busy_idle", {63'b0, busy}, 64'd0);
    endtask

    initial begin
        logic seen;
        aclr_n = 1'b0; clk_en = 1'b1; in_valid = 1'b0; in_mode = '0; in_tag = '0;
        dataa_mul = '0; datab_mul = '0; data_c = '0;
`ifdef BU_STICKY_FLAGS_EN
        clr_flags = 1'b0;
`endif
        repeat (2) @(posedge clock);
        #1;
        chk_eq("rst_valid",  {63'b0, out_valid}, 64'd0);
        chk_eq("rst_result", {32'b0, result},    64'd0);
        chk_eq("rst_tag",    {60'b0, out_tag},   64'd0);
        chk_eq("rst_flags",  {61'b0, zero, overflow, underflow}, 64'd0);
        chk_eq("rst_busy",   {63'b0, busy},      64'd0);
        aclr_n = 1'b1;
        @(posedge clock); #1;

        // 2*3 with c=1 across all four modes, then exact cancellations
        issue(32'h40000000, 32'h40400000, 32'h3F800000, 2'b00, 4'h1, 11);
        wait_drain();
        issue(32'h40000000, 32'h40400000, 32'h3F800000, 2'b01, 4'h2, 11);
        issue(32'h40000000, 32'h40400000, 32'h3F800000, 2'b10, 4'h3, 11);
        issue(32'h40000000, 32'h40400000, 32'h3F800000, 2'b11, 4'h4, 11);
        issue(32'h40000000, 32'h40400000, 32'h40C00000, 2'b01, 4'h5, 11);
        issue(32'h40000000, 32'h40400000, 32'h40C00000, 2'b10, 4'h6, 11);
        wait_drain();

        // Back-to-back stream, tags 0..F, each op with its own c
        for (int k = 0; k < 16; k++)
            issue(r2f(real'(k % 5 + 1)), 32'h40400000, r2f(real'(k)), 2'(k % 4), 4'(k), 11);
        wait_drain();

        // Three frozen cycles starting four cycles after issue
        issue(32'h40000000, 32'h40400000, 32'h3F800000, 2'b00, 4'h7, 14);
        for (int k = 1; k <= 14; k++) begin
            if (k == 4) clk_en = 1'b0;
            if (k == 7) clk_en = 1'b1;
            chk_eq("busy_hold", {63'b0, busy}, 64'd1);
            @(posedge clock); #1;
        end
        wait_drain();

        // Multiply overflow, then a clean op must clear the per-op flag
        issue(32'h7F000000, 32'h7F000000, 32'h3F800000, 2'b11, 4'h8, 11);
        issue(32'h40000000, 32'h40400000, 32'h3F800000, 2'b00, 4'h9, 11);
        wait_drain();
`ifdef BU_STICKY_FLAGS_EN
        chk_eq("sticky_ovf_set", {63'b0, sticky_ovf}, 64'd1);
        clr_flags = 1'b1;
        @(posedge clock); #1;
        clr_flags = 1'b0;
        chk_eq("sticky_ovf_clr", {63'b0, sticky_ovf}, 64'd0);
`endif

        // Reset with five ops in flight
        for (int k = 0; k < 5; k++)
            issue(32'h40000000, 32'h40400000, r2f(real'(k)), 2'b00, 4'(k + 10), 11);
        aclr_n = 1'b0;
        q.delete();
        #1;
        chk_eq("mid_rst_valid",  {63'b0, out_valid}, 64'd0);
        chk_eq("mid_rst_result", {32'b0, result},    64'd0);
        chk_eq("mid_rst_tag",    {60'b0, out_tag},   64'd0);
        chk_eq("mid_rst_busy",   {63'b0, busy},      64'd0);
        @(posedge clock); #1;
        aclr_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            seen = seen | out_valid;
        end
        #1;
        chk_eq("rst_quiet", {63'b0, seen}, 64'd0);
        chk_eq("rst_busy_after", {63'b0, busy}, 64'd0);
        @(posedge clock); #1;

        issue(32'h40400000, 32'h40400000, 32'h40000000, 2'b01, 4'hF, 11);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
